// File: rtl/galaga_rom_loader_if.sv
// Download bus between data_io and the galaga ROM loader.
// Carries the ioctl byte stream in and the region-decoded dn_* write port out.
// master: data_io / core side, slave: the loader.
interface galaga_rom_loader_if;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic [5:0]  dn_we;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        input  dn_addr, dn_data, dn_we
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
        output dn_addr, dn_data, dn_we
    );
endinterface

// File: rtl/galaga_rom_loader.sv
// Galaga ROM loader: registers the ioctl byte stream onto the core's dn_* port,
// decoding the linear address into a region strobe plus region-local offset,
// validates length and ordering, and keeps the core in reset until a complete
// image has been loaded.
// Optional feature macro: GALAGA_LOADER_SUM_EN (16-bit byte-sum check in CHECK).
// POST_HOLD must be at least 1.
module galaga_rom_loader #(
    parameter logic [15:0] EXPECT_LEN = 16'h9400,
    parameter logic [15:0] EXPECT_SUM = 16'h0000,
    parameter int          POST_HOLD  = 16
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    galaga_rom_loader_if.slave   io,
    output logic                 core_hold,
    output logic                 load_done,
    output logic                 load_err,
    output logic [15:0]          byte_count,
    output logic [15:0]          sum
);

    localparam int HW = (POST_HOLD > 1) ? $clog2(POST_HOLD) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERR} state_t;

    state_t        state, state_d;
    logic          dl_q;
    logic          dl_rise, dl_fall;
    logic          start;
    logic          addr_hit;
    logic          accept, drop;
    logic          bad;
    logic          sum_ok;
    logic          len_ok;
    logic [HW-1:0] hold_cnt;
    logic [15:0]   a16;
    logic [5:0]    dec_we;
    logic [15:0]   dec_off;

    assign dl_rise  = io.ioctl_download & ~dl_q;
    assign dl_fall  = ~io.ioctl_download & dl_q;
    assign start    = (state_d == S_LOAD) && (state != S_LOAD);
    // Comparing all 25 bits also rejects anything with ioctl_addr[24:16] set.
    assign addr_hit = (io.ioctl_addr == {9'd0, byte_count});
    // byte_count never passes EXPECT_LEN: overrun bytes only set the bad flag.
    assign accept   = (state == S_LOAD) && io.ioctl_wr && addr_hit && (byte_count < EXPECT_LEN);
    assign drop     = (state == S_LOAD) && io.ioctl_wr && !accept;
    assign len_ok   = (byte_count == EXPECT_LEN) && !bad;
    assign a16      = io.ioctl_addr[15:0];

    // Download strobe history for edge detection
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) dl_q <= 1'b0;
        else          dl_q <= io.ioctl_download;
    end

    // State register
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_d;
    end

    // Next state: a new download edge restarts from any settled state
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (dl_rise) state_d = S_LOAD;
            S_LOAD:  if (dl_fall) state_d = S_CHECK;
            S_CHECK: begin
                if (dl_rise)                state_d = S_LOAD;
                else if (len_ok && sum_ok)  state_d = S_DONE;
                else                        state_d = S_ERR;
            end
            S_DONE:  if (dl_rise) state_d = S_LOAD;
            S_ERR:   if (dl_rise) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Region decode of the low 16 address bits into strobe and local offset
    always_comb begin
        dec_we  = '0;
        dec_off = '0;
        if (a16 < 16'h4000) begin
            dec_we  = 6'b000001;
            dec_off = a16;
        end else if (a16 < 16'h5000) begin
            dec_we  = 6'b000010;
            dec_off = a16 - 16'h4000;
        end else if (a16 < 16'h6000) begin
            dec_we  = 6'b000100;
            dec_off = a16 - 16'h5000;
        end else if (a16 < 16'h7000) begin
            dec_we  = 6'b001000;
            dec_off = a16 - 16'h6000;
        end else if (a16 < 16'h9000) begin
            dec_we  = 6'b010000;
            dec_off = a16 - 16'h7000;
        end else if (a16 < 16'h9400) begin
            dec_we  = 6'b100000;
            dec_off = a16 - 16'h9000;
        end
    end

    // Core write port: one-cycle strobe per accepted byte, address/data held otherwise
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            io.dn_we   <= '0;
            io.dn_addr <= '0;
            io.dn_data <= '0;
        end else begin
            io.dn_we <= accept ? dec_we : 6'b000000;
            if (accept) begin
                io.dn_addr <= dec_off;
                io.dn_data <= io.ioctl_dout;
            end
        end
    end

    // Progress counter and sticky bad-order flag, cleared when a download starts
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            byte_count <= '0;
            bad        <= 1'b0;
        end else if (start) begin
            byte_count <= '0;
            bad        <= 1'b0;
        end else begin
            if (accept) byte_count <= byte_count + 16'd1;
            if (drop)   bad        <= 1'b1;
        end
    end

`ifdef GALAGA_LOADER_SUM_EN
    // Running 16-bit sum of accepted bytes
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n)    sum <= '0;
        else if (start)  sum <= '0;
        else if (accept) sum <= sum + {8'd0, io.ioctl_dout};
    end

    assign sum_ok = (sum == EXPECT_SUM);
`else
    // Without the sum check EXPECT_SUM has no effect.
    logic unused_expect_sum;

    assign unused_expect_sum = ^EXPECT_SUM;
    assign sum               = '0;
    assign sum_ok            = 1'b1;
`endif

    // Status flags and the post-load hold-off before releasing the core
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            core_hold <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            hold_cnt  <= '0;
        end else if (start) begin
            core_hold <= 1'b1;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            hold_cnt  <= '0;
        end else if (state == S_CHECK && state_d == S_DONE) begin
            load_done <= 1'b1;
            hold_cnt  <= '0;
        end else if (state == S_CHECK && state_d == S_ERR) begin
            load_err  <= 1'b1;
        end else if (state == S_DONE && core_hold) begin
            if (hold_cnt == HW'(POST_HOLD - 1)) core_hold <= 1'b0;
            else                                hold_cnt  <= hold_cnt + 1'b1;
        end
    end

endmodule
